// File: rtl/alu_pkg.sv
// Shared opcode encodings, data width and flag bundle for the execute-stage ALU.
// The divide opcode is only decoded when ALU_DIV_EN is defined.
package alu_pkg;

  localparam int unsigned XLEN = 32;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_NOR = 4'd6,
    OP_SLT = 4'd7,
    OP_SLL = 4'd8,
    OP_SRL = 4'd9,
    OP_SRA = 4'd10,
    OP_DIV = 4'd11
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic carry;
    logic sign;
    logic overflow;
  } alu_flags_t;

endpackage

// File: rtl/alu_divider.sv
// 32-bit unsigned restoring array divider, purely combinational.
// Built into risc_alu only when ALU_DIV_EN is defined.
module alu_divider
  import alu_pkg::*;
(
  input  logic [XLEN-1:0] dividend_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN-1:0] quotient_o,
  output logic [XLEN-1:0] remainder_o
);

  logic [XLEN:0]   rem;
  logic [XLEN:0]   diff;
  logic [XLEN-1:0] quot;

  // A zero divisor never borrows, so the array itself yields
  // an all-ones quotient and leaves the dividend as remainder.
  always_comb begin
    rem  = '0;
    diff = '0;
    quot = '0;
    for (int i = XLEN - 1; i >= 0; i--) begin
      rem  = {rem[XLEN-1:0], dividend_i[i]};
      diff = rem - {1'b0, divisor_i};
      if (!diff[XLEN]) begin
        rem     = diff;
        quot[i] = 1'b1;
      end
    end
  end

  assign quotient_o  = quot;
  assign remainder_o = rem[XLEN-1:0];

endmodule

// File: rtl/risc_alu.sv
// Execute-stage integer ALU: one combinational op mux into one output register bank.
// Define ALU_DIV_EN to build the unsigned divider behind opcode 11.
module risc_alu
  import alu_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      control,
  output logic [XLEN-1:0] result_1,
  output logic [XLEN-1:0] result_2,
  output logic            zero_flag,
  output logic            carry_flag,
  output logic            sign_flag,
  output logic            overflow_flag
);

  logic [XLEN-1:0]   r1_d, r1_q;
  logic [XLEN-1:0]   r2_d, r2_q;
  alu_flags_t        fl_d, fl_q;

  logic [XLEN:0]     add_w;
  logic [XLEN-1:0]   sub_w;
  logic [2*XLEN-1:0] mul_w;
  logic [4:0]        shamt;

  assign add_w = {1'b0, a} + {1'b0, b};
  assign sub_w = a - b;
  assign mul_w = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
  assign shamt = b[4:0];

`ifdef ALU_DIV_EN
  logic [XLEN-1:0] div_q;
  logic [XLEN-1:0] div_r;

  alu_divider u_div (
    .dividend_i  (a),
    .divisor_i   (b),
    .quotient_o  (div_q),
    .remainder_o (div_r)
  );
`endif

  always_comb begin
    r1_d          = '0;
    r2_d          = '0;
    fl_d          = '0;
    case (control)
      OP_ADD: begin
        r1_d          = add_w[XLEN-1:0];
        fl_d.carry    = add_w[XLEN];
        fl_d.overflow = (a[XLEN-1] == b[XLEN-1]) &&
                        (add_w[XLEN-1] != a[XLEN-1]);
      end
      OP_SUB: begin
        r1_d          = sub_w;
        fl_d.carry    = a < b;
        fl_d.overflow = (a[XLEN-1] != b[XLEN-1]) &&
                        (sub_w[XLEN-1] != a[XLEN-1]);
      end
      OP_MUL: begin
        r1_d = mul_w[XLEN-1:0];
        r2_d = mul_w[2*XLEN-1:XLEN];
      end
      OP_AND: r1_d = a & b;
      OP_OR:  r1_d = a | b;
      OP_XOR: r1_d = a ^ b;
      OP_NOR: r1_d = ~(a | b);
      OP_SLT: r1_d = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OP_SLL: r1_d = a << shamt;
      OP_SRL: r1_d = a >> shamt;
      OP_SRA: r1_d = $unsigned($signed(a) >>> shamt);
`ifdef ALU_DIV_EN
      OP_DIV: begin
        r1_d = div_q;
        r2_d = div_r;
      end
`endif
      default: begin
        r1_d = '0;
        r2_d = '0;
      end
    endcase
    fl_d.zero = (r1_d == '0);
    fl_d.sign = r1_d[XLEN-1];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r1_q <= '0;
      r2_q <= '0;
      fl_q <= '0;
    end else begin
      r1_q <= r1_d;
      r2_q <= r2_d;
      fl_q <= fl_d;
    end
  end

  assign result_1      = r1_q;
  assign result_2      = r2_q;
  assign zero_flag     = fl_q.zero;
  assign carry_flag    = fl_q.carry;
  assign sign_flag     = fl_q.sign;
  assign overflow_flag = fl_q.overflow;

endmodule

// File: tb/tb_risc_alu.sv
// Directed-vector bench for risc_alu; flags compared as {zero,carry,sign,overflow}.
// Divide vectors run when ALU_DIV_EN is defined, otherwise opcode 11 is checked as reserved.
module tb_risc_alu;

  logic        clk;
  logic        rst;
  logic [31:0] a;
  logic [31:0] b;
  logic [3:0]  control;
  logic [31:0] result_1;
  logic [31:0] result_2;
  logic        zero_flag;
  logic        carry_flag;
  logic        sign_flag;
  logic        overflow_flag;

  int checks = 0;
  int errors = 0;

  risc_alu dut (
    .clk           (clk),
    .rst           (rst),
    .a             (a),
    .b             (b),
    .control       (control),
    .result_1      (result_1),
    .result_2      (result_2),
    .zero_flag     (zero_flag),
    .carry_flag    (carry_flag),
    .sign_flag     (sign_flag),
    .overflow_flag (overflow_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input string tag, input logic [3:0] c,
                      input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] e1, input logic [31:0] e2,
                      input logic [3:0] ef);
    @(negedge clk);
    control = c;
    a       = x;
    b       = y;
    @(posedge clk);
    #1;
    chk({tag, ".r1"}, result_1, e1);
    chk({tag, ".r2"}, result_2, e2);
    chk({tag, ".flags"}, {28'd0, zero_flag, carry_flag,
                          sign_flag, overflow_flag}, {28'd0, ef});
  endtask

  initial begin
    rst     = 1'b1;
    a       = '0;
    b       = '0;
    control = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.r1", result_1, 32'h0);
    chk("reset.r2", result_2, 32'h0);
    chk("reset.flags", {28'd0, zero_flag, carry_flag,
                        sign_flag, overflow_flag}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    step("add_small", 4'd0, 32'd20, 32'd10, 32'd30, 32'd0, 4'b0000);
    step("add_ovf", 4'd0, 32'h7FFFFFFF, 32'h7FFFFFFF,
         32'hFFFFFFFE, 32'd0, 4'b0011);
    step("add_carry", 4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
         32'hFFFFFFFE, 32'd0, 4'b0110);
    step("sub_borrow", 4'd1, 32'd5, 32'd7,
         32'hFFFFFFFE, 32'd0, 4'b0110);
    step("sub_ovf", 4'd1, 32'h80000000, 32'd1,
         32'h7FFFFFFF, 32'd0, 4'b0001);
    step("sub_zero", 4'd1, 32'd5, 32'd5, 32'd0, 32'd0, 4'b1000);
    step("mul_max", 4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF,
         32'h00000001, 32'hFFFFFFFE, 4'b0000);
    step("and", 4'd3, 32'hFFA47A78, 32'h0FAEFF12,
         32'h0FA47A10, 32'd0, 4'b0000);
    step("or", 4'd4, 32'hFFAAAA78, 32'h03A33F12,
         32'hFFABBF7A, 32'd0, 4'b0010);
    step("xor", 4'd5, 32'hA5A5A5A5, 32'hFFFFFFFF,
         32'h5A5A5A5A, 32'd0, 4'b0000);
    step("nor", 4'd6, 32'h00A11A78, 32'h03AEFF36,
         32'hFC500081, 32'd0, 4'b0010);
    step("slt_true", 4'd7, 32'hFFFFFFFF, 32'd1, 32'd1, 32'd0, 4'b0000);
    step("slt_false", 4'd7, 32'd1, 32'hFFFFFFFF, 32'd0, 32'd0, 4'b1000);
    step("sll_31", 4'd8, 32'd1, 32'd31, 32'h80000000, 32'd0, 4'b0010);
    step("sll_mask", 4'd8, 32'd1, 32'h00000023, 32'd8, 32'd0, 4'b0000);
    step("srl", 4'd9, 32'h80000000, 32'd4, 32'h08000000, 32'd0, 4'b0000);
    step("sra", 4'd10, 32'h80000000, 32'd4,
         32'hF8000000, 32'd0, 4'b0010);
`ifdef ALU_DIV_EN
    step("div", 4'd11, 32'd100, 32'd7, 32'd14, 32'd2, 4'b0000);
    step("div_zero", 4'd11, 32'd5, 32'd0,
         32'hFFFFFFFF, 32'd5, 4'b0010);
`else
    step("op11_rsvd", 4'd11, 32'd100, 32'd7, 32'd0, 32'd0, 4'b1000);
`endif
    step("op13_rsvd", 4'd13, 32'h12345678, 32'h9ABCDEF0,
         32'd0, 32'd0, 4'b1000);
    step("op15_rsvd", 4'd15, 32'hFFFFFFFF, 32'hFFFFFFFF,
         32'd0, 32'd0, 4'b1000);

    step("pre_rst", 4'd0, 32'hFFFFFFFF, 32'hFFFFFFFF,
         32'hFFFFFFFE, 32'd0, 4'b0110);
    @(negedge clk);
    rst     = 1'b1;
    control = 4'd0;
    a       = 32'd1;
    b       = 32'd1;
    @(posedge clk);
    #1;
    chk("mid_rst.r1", result_1, 32'h0);
    chk("mid_rst.r2", result_2, 32'h0);
    chk("mid_rst.flags", {28'd0, zero_flag, carry_flag,
                          sign_flag, overflow_flag}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    step("post_rst", 4'd0, 32'd1, 32'd1, 32'd2, 32'd0, 4'b0000);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
